medicine_dose_scheduler: RTL and testbench

//  Sits downstream of the ROM medicine-selection stage: captures each selected (medicine address,

---
 rtl/medicine_dose_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_medicine_dose_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/medicine_dose_scheduler.sv
// ---------------------------------------------------------------------------
// medicine_dose_scheduler
//
// Purpose:
//   Captures selected (medicine id, dose interval) pairs into a small slot
//   table and runs one countdown per slot, driven by a prescaled time-base
//   tick. An expired countdown marks its slot pending. A small FSM then
//   raises a dose alarm that carries the medicine id until the user
//   acknowledges it. The acknowledge re-arms that slot. After each alarm the
//   FSM spends one GAP cycle with the alarm low, so that back-to-back alarms
//   are visibly separated.
//
// Ports:
//   Clk           in   rising-edge system clock
//   Rst           in   synchronous reset, active-low
//   Load_Valid    in   1-cycle strobe qualifying Load_Address/Load_Data
//   Load_Address  in   medicine id to track
//   Load_Data     in   dose interval in time units (0 is rejected)
//   Tick_In       in   time-base pulse, TICKS_PER_UNIT pulses per unit
//   Ack_Button    in   user acknowledge level, rising edge acts
//   Clear_All     in   drop all slots and alarms
//   Alarm_Out     out  dose alarm active
//   Alarm_Med_Id  out  medicine id of active alarm (0 when idle)
//   Alarm_Slot    out  slot index of active alarm (0 when idle)
//   Slots_Used    out  number of valid slots
//   Full_Out      out  every slot in use
//   Load_Reject   out  1-cycle pulse, previous load was refused
// ---------------------------------------------------------------------------
module medicine_dose_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 4,
  parameter int TICKS_PER_UNIT = 60,
  localparam int SLOT_W = $clog2(NUM_SLOTS),
  localparam int USED_W = $clog2(NUM_SLOTS + 1),
  localparam int PRE_W  = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Load_Valid,
  input  logic [ADDR_W-1:0] Load_Address,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic              Tick_In,
  input  logic              Ack_Button,
  input  logic              Clear_All,
  output logic              Alarm_Out,
  output logic [ADDR_W-1:0] Alarm_Med_Id,
  output logic [SLOT_W-1:0] Alarm_Slot,
  output logic [USED_W-1:0] Slots_Used,
  output logic              Full_Out,
  output logic              Load_Reject
);

  typedef enum logic [1:0] {IDLE, ALERT, GAP} state_t;

  state_t              state_q, state_d;
  logic [NUM_SLOTS-1:0] valid_q, pending_q;
  logic [ADDR_W-1:0]   id_q       [NUM_SLOTS];
  logic [DATA_W-1:0]   interval_q [NUM_SLOTS];
  logic [DATA_W-1:0]   count_q    [NUM_SLOTS];
  logic [PRE_W-1:0]    prescale_q;
  logic                ack_prev_q;

  logic                match_hit, free_hit, load_ok, reject_d;
  logic [SLOT_W-1:0]   match_idx, free_idx, load_idx;
  logic                pend_any;
  logic [SLOT_W-1:0]   pend_idx;
  logic                unit_tick, ack_rise, ack_fire;
  logic                alarm_d;
  logic [ADDR_W-1:0]   med_id_d;
  logic [SLOT_W-1:0]   slot_d;

  // Slot lookup. A matching id takes precedence over a free slot, so a
  // reload never consumes a second slot. The loops scan downwards, so the
  // lowest index found is the one that remains.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    pend_any  = 1'b0;
    pend_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_q[i] && (id_q[i] == Load_Address)) begin
        match_hit = 1'b1;
        match_idx = SLOT_W'(i);
      end
      if (!valid_q[i]) begin
        free_hit = 1'b1;
        free_idx = SLOT_W'(i);
      end
      if (pending_q[i]) begin
        pend_any = 1'b1;
        pend_idx = SLOT_W'(i);
      end
    end
  end

  assign load_ok   = Load_Valid && (Load_Data != '0) && (match_hit || free_hit);
  assign load_idx  = match_hit ? match_idx : free_idx;
  assign reject_d  = Load_Valid && !load_ok;
  assign unit_tick = Tick_In && (prescale_q == PRE_W'(TICKS_PER_UNIT - 1));
  assign ack_rise  = Ack_Button && !ack_prev_q;

  // Population count of the valid bits.
  always_comb begin
    Slots_Used = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      Slots_Used = Slots_Used + USED_W'(valid_q[i]);
    end
  end

  assign Full_Out = (Slots_Used == USED_W'(NUM_SLOTS));

  // Alarm FSM next-state logic. The alarm outputs are computed here and
  // registered with the state, so they change on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    alarm_d  = Alarm_Out;
    med_id_d = Alarm_Med_Id;
    slot_d   = Alarm_Slot;
    ack_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_any) begin
          state_d  = ALERT;
          alarm_d  = 1'b1;
          slot_d   = pend_idx;
          med_id_d = id_q[pend_idx];
        end
      end
      ALERT: begin
        if (ack_rise) begin
          ack_fire = 1'b1;
          state_d  = GAP;
          alarm_d  = 1'b0;
          slot_d   = '0;
          med_id_d = '0;
        end
      end
      GAP: begin
        state_d  = IDLE;
        alarm_d  = 1'b0;
        slot_d   = '0;
        med_id_d = '0;
      end
      default: begin
        state_d  = IDLE;
        alarm_d  = 1'b0;
        slot_d   = '0;
        med_id_d = '0;
      end
    endcase
  end

  // FSM state, registered alarm outputs and reject pulse. The Ack_Button
  // history keeps tracking through Clear_All, so that a button which is
  // still held afterwards is not seen as a new press.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q      <= IDLE;
      Alarm_Out    <= 1'b0;
      Alarm_Med_Id <= '0;
      Alarm_Slot   <= '0;
      Load_Reject  <= 1'b0;
      ack_prev_q   <= 1'b0;
    end else begin
      ack_prev_q <= Ack_Button;
      if (Clear_All) begin
        state_q      <= IDLE;
        Alarm_Out    <= 1'b0;
        Alarm_Med_Id <= '0;
        Alarm_Slot   <= '0;
        Load_Reject  <= 1'b0;
      end else begin
        state_q      <= state_d;
        Alarm_Out    <= alarm_d;
        Alarm_Med_Id <= med_id_d;
        Alarm_Slot   <= slot_d;
        Load_Reject  <= reject_d;
      end
    end
  end

  // Slot table and prescaler. For each slot the order of precedence is:
  // a load, then an acknowledge re-arm, then a countdown decrement. A load
  // that hits the slot under acknowledge still clears its pending bit.
  always_ff @(posedge Clk) begin
    if (!Rst || Clear_All) begin
      valid_q    <= '0;
      pending_q  <= '0;
      prescale_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        count_q[i] <= '0;
        if (!Rst) begin
          id_q[i]       <= '0;
          interval_q[i] <= '0;
        end
      end
    end else begin
      if (Tick_In) begin
        prescale_q <= unit_tick ? '0 : prescale_q + 1'b1;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (load_ok && (load_idx == SLOT_W'(i))) begin
          count_q[i]    <= Load_Data;
          interval_q[i] <= Load_Data;
          if (!match_hit) begin
            valid_q[i]   <= 1'b1;
            id_q[i]      <= Load_Address;
            pending_q[i] <= 1'b0;
          end else if (ack_fire && (Alarm_Slot == SLOT_W'(i))) begin
            pending_q[i] <= 1'b0;
          end
        end else if (ack_fire && (Alarm_Slot == SLOT_W'(i))) begin
          pending_q[i] <= 1'b0;
          count_q[i]   <= interval_q[i];
        end else if (unit_tick && valid_q[i] && !pending_q[i] && (count_q[i] != '0)) begin
          count_q[i] <= count_q[i] - 1'b1;
          if (count_q[i] == DATA_W'(1)) begin
            pending_q[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_medicine_dose_scheduler.sv
// ---------------------------------------------------------------------------
// tb_medicine_dose_scheduler
//
// Self-checking bench for medicine_dose_scheduler with NUM_SLOTS=4 and
// TICKS_PER_UNIT=2. A table of per-cycle vectors holds the inputs and the
// outputs expected after that edge. The expected outputs are queued when the
// inputs are driven, then popped and compared once the edge has passed. A
// final hand-written sequence checks that an interval updated during an
// alarm is the one used to re-arm the slot.
// ---------------------------------------------------------------------------
module tb_medicine_dose_scheduler;

  localparam int NS  = 4;
  localparam int AW  = 6;
  localparam int DW  = 4;
  localparam int TPU = 2;

  typedef struct packed {
    logic          aout;
    logic [AW-1:0] aid;
    logic [1:0]    aslot;
    logic [2:0]    used;
    logic          full;
    logic          rej;
  } exp_t;

  typedef struct packed {
    logic          rst;
    logic          lv;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          tick;
    logic          ack;
    logic          clr;
    exp_t          exp;
  } vec_t;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Load_Valid = 1'b0;
  logic [AW-1:0] Load_Address = '0;
  logic [DW-1:0] Load_Data = '0;
  logic          Tick_In = 1'b0;
  logic          Ack_Button = 1'b0;
  logic          Clear_All = 1'b0;
  logic          Alarm_Out;
  logic [AW-1:0] Alarm_Med_Id;
  logic [1:0]    Alarm_Slot;
  logic [2:0]    Slots_Used;
  logic          Full_Out;
  logic          Load_Reject;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   compared   = 0;
  int   mismatched = 0;

  medicine_dose_scheduler #(
    .NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW), .TICKS_PER_UNIT(TPU)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Load_Valid(Load_Valid), .Load_Address(Load_Address),
    .Load_Data(Load_Data), .Tick_In(Tick_In), .Ack_Button(Ack_Button),
    .Clear_All(Clear_All), .Alarm_Out(Alarm_Out), .Alarm_Med_Id(Alarm_Med_Id),
    .Alarm_Slot(Alarm_Slot), .Slots_Used(Slots_Used), .Full_Out(Full_Out),
    .Load_Reject(Load_Reject)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t v(input logic rst, input logic lv, input int addr, input int data,
                             input logic tick, input logic ack, input logic clr,
                             input logic aout, input int aid, input int aslot,
                             input int used, input logic full, input logic rej);
    vec_t t;
    t.rst       = rst;
    t.lv        = lv;
    t.addr      = AW'(addr);
    t.data      = DW'(data);
    t.tick      = tick;
    t.ack       = ack;
    t.clr       = clr;
    t.exp.aout  = aout;
    t.exp.aid   = AW'(aid);
    t.exp.aslot = 2'(aslot);
    t.exp.used  = 3'(used);
    t.exp.full  = full;
    t.exp.rej   = rej;
    return t;
  endfunction

  // Drive one cycle of inputs on the falling edge, queue its expectation,
  // then move to just after the following rising edge.
  task automatic applyStimulus(input vec_t t);
    @(negedge Clk);
    Rst          = t.rst;
    Load_Valid   = t.lv;
    Load_Address = t.addr;
    Load_Data    = t.data;
    Tick_In      = t.tick;
    Ack_Button   = t.ack;
    Clear_All    = t.clr;
    exp_q.push_back(t.exp);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    exp_t a;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL %s: no expectation queued", name);
    end else begin
      e = exp_q.pop_front();
      a = {Alarm_Out, Alarm_Med_Id, Alarm_Slot, Slots_Used, Full_Out, Load_Reject};
      if (a !== e) begin
        mismatched++;
        $display("[TB] FAIL %s: got alarm=%0b id=%0d slot=%0d used=%0d full=%0b rej=%0b, expected alarm=%0b id=%0d slot=%0d used=%0d full=%0b rej=%0b",
                 name, a.aout, a.aid, a.aslot, a.used, a.full, a.rej,
                 e.aout, e.aid, e.aslot, e.used, e.full, e.rej);
      end
    end
  endtask

  initial begin
    int waited;
    bit found;

    // Reset, then a single slot (id 5, interval 3) expiring after 6 ticks.
    tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,1,5,3,0,0,0, 0,0,0,1,0,0));
    for (int i = 0; i < 6; i++) tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,5,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,5,0,1,0,0));
    // Ack rises: GAP, then IDLE while the button stays held.
    for (int i = 0; i < 3; i++) tbl.push_back(v(1,0,0,0,0,1,0, 0,0,0,1,0,0));
    // Six more ticks with ack still held, then the alarm returns and is not acked.
    for (int i = 0; i < 6; i++) tbl.push_back(v(1,0,0,0,1,1,0, 0,0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,1,0, 1,5,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,1,0, 1,5,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,5,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,1,0, 0,0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,1,0,0));

    // Fill the table, overflow, reload an existing id, and reject a zero interval.
    tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,1,1,5,0,0,0, 0,0,0,1,0,0));
    tbl.push_back(v(1,1,2,5,0,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,1,3,5,0,0,0, 0,0,0,3,0,0));
    tbl.push_back(v(1,1,4,5,0,0,0, 0,0,0,4,1,0));
    tbl.push_back(v(1,1,9,5,0,0,0, 0,0,0,4,1,1));
    tbl.push_back(v(1,1,2,7,0,0,0, 0,0,0,4,1,0));
    tbl.push_back(v(1,1,6,0,0,0,0, 0,0,0,4,1,1));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,4,1,0));

    // Two slots expire on the same unit tick and are served in index order.
    tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,1,1,1,0,0,0, 0,0,0,1,0,0));
    tbl.push_back(v(1,1,2,1,0,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,1,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,1,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,2,1,2,0,0));
    tbl.push_back(v(1,0,0,0,0,1,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,2,0,0));

    // Clear_All while an alarm is active.
    tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 1,1,0,2,0,0));
    tbl.push_back(v(1,0,0,0,0,0,1, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0));

    // Reset in the middle of a countdown, then ticks with no slots loaded.
    tbl.push_back(v(1,1,7,2,0,0,0, 0,0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,1,0,0));
    tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1,0,0,0,1,0,0, 0,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Reload the alerting id with a new interval, then check that the ack
    // re-arms the slot with that interval (2 units = 4 ticks).
    applyStimulus(v(1,1,8,1,0,0,0, 0,0,0,1,0,0)); checkOutput("reload_load");
    applyStimulus(v(1,0,0,0,1,0,0, 0,0,0,1,0,0)); checkOutput("reload_tick1");
    applyStimulus(v(1,0,0,0,1,0,0, 0,0,0,1,0,0)); checkOutput("reload_tick2");
    applyStimulus(v(1,0,0,0,0,0,0, 1,8,0,1,0,0)); checkOutput("reload_alarm");
    applyStimulus(v(1,1,8,2,0,0,0, 1,8,0,1,0,0)); checkOutput("reload_update");
    applyStimulus(v(1,0,0,0,0,1,0, 0,0,0,1,0,0)); checkOutput("reload_ack");
    applyStimulus(v(1,0,0,0,0,0,0, 0,0,0,1,0,0)); checkOutput("reload_idle");

    waited = 0;
    found  = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge Clk);
      Load_Valid = 1'b0;
      Ack_Button = 1'b0;
      Tick_In    = 1'b1;
      @(posedge Clk);
      #1;
      if (Alarm_Out) begin
        found  = 1'b1;
        waited = k;
      end
    end
    Tick_In = 1'b0;
    compared++;
    if (!found || waited != 5) begin
      mismatched++;
      $display("[TB] FAIL rearm_latency: got %0d cycles (found=%0b), expected 5", waited, found);
    end
    compared++;
    if (Alarm_Med_Id !== AW'(8)) begin
      mismatched++;
      $display("[TB] FAIL rearm_id: got %0d, expected 8", Alarm_Med_Id);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
